uart_baud_gen_frac: RTL and testbench
=====================================

# uart_baud_gen_frac

Parametrised baud-rate tick generator for the CoreUARTapb family. It generalises the fixed 13-bit, 16x, 3-bit-fraction generator to a configurable counter width, fractional resolution and oversampling ratio. It also adds a mid-bit sample strobe, receiver phase re-alignment, a count enable and a synchronous reload. It sits between the APB register block (baud_val, baud_frac) and the UART transmit/receive state machines.

## Interface
- CNT_WIDTH, 16: width of baud_val; integer divisor range 1..2^CNT_WIDTH.
- FRAC_WIDTH, 4: width of baud_frac; fractional resolution 1/2^FRAC_WIDTH. Legal range 1..8.
- OVERSAMPLE, 16: baud ticks per bit. Power of two, 4..32. OS_WIDTH = log2(OVERSAMPLE).

- clk  in  1  system clock.
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- enable  in  1  count enable; low freezes all state.
- load  in  1  synchronous restart of divider, accumulator and phase.
- rx_align  in  1  receiver start-bit detect; restarts divider and phase.
- baud_val  in  CNT_WIDTH  integer divisor minus one.
- baud_frac  in  FRAC_WIDTH  fractional divisor numerator.
- baud_clock  out  1  oversample tick, one cycle wide.
- xmit_pulse  out  1  bit-rate tick, coincident with every OVERSAMPLE-th baud_clock.
- sample_pulse  out  1  mid-bit tick, coincident with the (OVERSAMPLE/2)-th baud_clock.
- phase  out  OS_WIDTH  current oversample phase count.

## Operation
- State:
  - cnt: CNT_WIDTH+1 bits, down-counter.
  - acc: FRAC_WIDTH bits, fractional accumulator.
  - os_cnt: OS_WIDTH bits, drives the phase output.
- Priority per edge: load > rx_align > !enable > normal.
- load=1:
  - cnt <= baud_val, acc <= 0, os_cnt <= 0.
  - All pulse outputs 0 this cycle.
  - Takes effect regardless of enable.
- rx_align=1 (load=0):
  - cnt <= baud_val, os_cnt <= 0, acc unchanged.
  - Pulse outputs 0 this cycle.
- enable=0: cnt, acc and os_cnt hold; pulse outputs 0.
- Normal, cnt != 0: cnt <= cnt - 1; pulse outputs 0.
- Normal, cnt == 0 (tick):
  - {carry, acc_next} = acc + baud_frac, computed at FRAC_WIDTH+1 bits.
  - acc <= acc_next.
  - cnt <= baud_val + carry, computed at CNT_WIDTH+1 bits with no overflow.
  - baud_clock <= 1.
  - os_cnt <= os_cnt + 1, wrapping mod OVERSAMPLE.
  - xmit_pulse <= (os_cnt == OVERSAMPLE-1).
  - sample_pulse <= (os_cnt == OVERSAMPLE/2-1).
- Tick period:
  - Tick-to-tick period = baud_val+1+carry cycles.
  - Long-run average = baud_val+1+baud_frac/2^FRAC_WIDTH.
  - baud_frac=0 gives an exact integer divider.
- baud_val or baud_frac changing mid-count: takes effect at the next reload only. The count in progress is not truncated.
- baud_val=0, baud_frac=0: baud_clock high every cycle.
- Reset (async, any time):
  - cnt=0, acc=0, os_cnt=0.
  - baud_clock, xmit_pulse, sample_pulse = 0; phase = 0.
  - Outputs go low immediately, without waiting for clk.

## Timing
- All outputs registered; no combinational input-to-output path.
- First tick after reset release with enable=1: cnt is 0, so baud_clock is high in the cycle after the first active edge.
- Edge-level example, baud_val=3, no carry:
  - Tick edge reloads cnt=3.
  - Edges +1..+3 decrement cnt to 0.
  - Edge +4 ticks again; period is 4 cycles.
- xmit_pulse and sample_pulse are only ever high in a cycle where baud_clock is high.
- After load or rx_align at edge E:
  - First baud_clock follows edge E+baud_val+1.
  - sample_pulse rides the (OVERSAMPLE/2)-th tick after E.
  - xmit_pulse rides the OVERSAMPLE-th tick after E.
- load and rx_align in the same cycle: load wins, acc cleared.
- enable deasserted on a tick edge: no tick, state frozen with cnt==0. The tick fires on the first edge after enable returns.

## Test plan
- Defaults, baud_val=3, baud_frac=0, enable=1:
  - baud_clock every 4 cycles.
  - sample_pulse on ticks 8, 24, …; xmit_pulse on ticks 16, 32, ….
  - xmit_pulse every 64 cycles.
- baud_val=3, baud_frac=8 after load:
  - Periods alternate 4, 5 (first 4).
  - 32 ticks span exactly 144 cycles.
- baud_val=0, baud_frac=15 after load: 16 consecutive ticks span 31 cycles; exactly one period has length 1.
- Free-running at phase=5, pulse rx_align:
  - phase reads 0.
  - With baud_val=3: sample_pulse at exactly 32 cycles after the align edge, xmit_pulse at 64.
- enable low for 10 cycles mid-count (cnt=2), plus a baud_val change 3→7 while low:
  - No pulses while low; cnt, acc and phase frozen.
  - On resume the current period completes with the old count.
  - Following periods are 8 cycles.
- Mid-operation reset_n low for 1 cycle, not clock-aligned: all outputs and phase 0 immediately. load + rx_align together: acc is 0 afterwards.

Source files
------------

// File: rtl/uart_baud_gen_frac_if.sv
// ============================================================================
// Module   : uart_baud_gen_frac_if
// Brief    : Register-block / UART-FSM side bundle of the fractional baud
//            tick generator (divisor inputs, control strobes, tick outputs).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_baud_gen_frac_if #(
  parameter int CNT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 4,
  parameter int OVERSAMPLE = 16
);
  localparam int c_os_width = $clog2(OVERSAMPLE);

  logic                  enable;
  logic                  load;
  logic                  rx_align;
  logic [CNT_WIDTH-1:0]  baud_val;
  logic [FRAC_WIDTH-1:0] baud_frac;
  logic                  baud_clock;
  logic                  xmit_pulse;
  logic                  sample_pulse;
  logic [c_os_width-1:0] phase;

  modport master (
    output enable, load, rx_align, baud_val, baud_frac,
    input  baud_clock, xmit_pulse, sample_pulse, phase
  );

  modport slave (
    input  enable, load, rx_align, baud_val, baud_frac,
    output baud_clock, xmit_pulse, sample_pulse, phase
  );
endinterface

`default_nettype wire

// File: rtl/uart_baud_gen_frac.sv
// ============================================================================
// Module   : uart_baud_gen_frac
// Brief    : Fractional-N baud tick generator with oversample phase counter,
//            mid-bit sample strobe, receiver re-alignment and count enable.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_baud_gen_frac #(
  parameter int CNT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 4,
  parameter int OVERSAMPLE = 16
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  uart_baud_gen_frac_if.slave bus
);
  localparam int                    c_os_width = $clog2(OVERSAMPLE);
  localparam logic [c_os_width-1:0] c_os_last  = c_os_width'(OVERSAMPLE - 1);
  localparam logic [c_os_width-1:0] c_os_mid   = c_os_width'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_WIDTH:0]    c_cnt_one  = (CNT_WIDTH + 1)'(1);
  localparam logic [c_os_width-1:0] c_os_one   = c_os_width'(1);

  logic [CNT_WIDTH:0]    r_cnt;
  logic [FRAC_WIDTH-1:0] r_acc;
  logic [c_os_width-1:0] r_os_cnt;
  logic                  r_baud_clock;
  logic                  r_xmit_pulse;
  logic                  r_sample_pulse;

  logic [FRAC_WIDTH:0]   w_acc_sum;
  logic [CNT_WIDTH:0]    w_reload;
  logic [CNT_WIDTH:0]    w_cnt_next;
  logic [FRAC_WIDTH-1:0] w_acc_next;
  logic [c_os_width-1:0] w_os_next;
  logic                  w_baud_clock_next;
  logic                  w_xmit_next;
  logic                  w_sample_next;

  // The extra counter bit lets baud_val plus the fractional carry reload
  // without wrapping at the top of the divisor range.
  assign w_acc_sum = {1'b0, r_acc} + {1'b0, bus.baud_frac};
  assign w_reload  = {1'b0, bus.baud_val} + {{CNT_WIDTH{1'b0}}, w_acc_sum[FRAC_WIDTH]};

  always_comb begin
    w_cnt_next        = r_cnt;
    w_acc_next        = r_acc;
    w_os_next         = r_os_cnt;
    w_baud_clock_next = 1'b0;
    w_xmit_next       = 1'b0;
    w_sample_next     = 1'b0;
    if (bus.load) begin
      w_cnt_next = {1'b0, bus.baud_val};
      w_acc_next = '0;
      w_os_next  = '0;
    end else if (bus.rx_align) begin
      w_cnt_next = {1'b0, bus.baud_val};
      w_os_next  = '0;
    end else if (bus.enable) begin
      if (r_cnt != '0) begin
        w_cnt_next = r_cnt - c_cnt_one;
      end else begin
        w_cnt_next        = w_reload;
        w_acc_next        = w_acc_sum[FRAC_WIDTH-1:0];
        w_os_next         = r_os_cnt + c_os_one;
        w_baud_clock_next = 1'b1;
        w_xmit_next       = (r_os_cnt == c_os_last);
        w_sample_next     = (r_os_cnt == c_os_mid);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt          <= '0;
      r_acc          <= '0;
      r_os_cnt       <= '0;
      r_baud_clock   <= 1'b0;
      r_xmit_pulse   <= 1'b0;
      r_sample_pulse <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_next;
      r_acc          <= w_acc_next;
      r_os_cnt       <= w_os_next;
      r_baud_clock   <= w_baud_clock_next;
      r_xmit_pulse   <= w_xmit_next;
      r_sample_pulse <= w_sample_next;
    end
  end

  assign bus.baud_clock   = r_baud_clock;
  assign bus.xmit_pulse   = r_xmit_pulse;
  assign bus.sample_pulse = r_sample_pulse;
  assign bus.phase        = r_os_cnt;

endmodule

`default_nettype wire

// File: tb/tb_uart_baud_gen_frac.sv
// ============================================================================
// Module   : tb_uart_baud_gen_frac
// Brief    : Scoreboard bench for uart_baud_gen_frac using directed scenarios.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_baud_gen_frac;
  localparam int CW = 16;
  localparam int FW = 4;
  localparam int OS = 16;

  typedef struct {
    int cyc;
    bit xmit;
    bit sample;
    int phase;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   armed = 1'b0;
  exp_t q[$];

  uart_baud_gen_frac_if #(.CNT_WIDTH(CW), .FRAC_WIDTH(FW), .OVERSAMPLE(OS)) bif ();

  uart_baud_gen_frac #(.CNT_WIDTH(CW), .FRAC_WIDTH(FW), .OVERSAMPLE(OS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Expected tick schedule: cycle index of each baud_clock and its strobes
  task automatic sched(input int first, input int bv, input int frac, input int n, input int ph0);
    int t;
    int acc;
    int ph;
    int carry;
    exp_t e;
    t = first;
    acc = 0;
    ph = ph0;
    for (int k = 0; k < n; k++) begin
      ph = (ph + 1) % OS;
      e.cyc = t;
      e.xmit = (ph == 0);
      e.sample = (ph == OS / 2);
      e.phase = ph;
      q.push_back(e);
      acc = acc + frac;
      carry = (acc >= (1 << FW)) ? 1 : 0;
      acc = acc % (1 << FW);
      t = t + bv + 1 + carry;
    end
    armed = 1'b1;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n;
    n = 0;
    while (armed && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (armed) begin
      checks++;
      errors++;
      $display("FAIL %s: %0d expected ticks still pending after %0d cycles, required 0", name, q.size(), limit);
      q.delete();
      armed = 1'b0;
    end
  endtask

  task automatic do_load(input int bv, input int frac, output int e);
    q.delete();
    armed = 1'b0;
    bif.baud_val = CW'(bv);
    bif.baud_frac = FW'(frac);
    bif.load = 1'b1;
    e = cyc + 1;
    step_to(e);
    bif.load = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      checks++;
      if ((bif.xmit_pulse || bif.sample_pulse) && !bif.baud_clock) begin
        errors++;
        $display("FAIL strobe_without_tick: cyc=%0d xmit=%0b sample=%0b baud_clock=%0b, required baud_clock=1",
                 cyc, bif.xmit_pulse, bif.sample_pulse, bif.baud_clock);
      end
      if (bif.baud_clock && armed) begin
        e = q.pop_front();
        checks++;
        if (cyc != e.cyc || bif.xmit_pulse != e.xmit || bif.sample_pulse != e.sample ||
            int'(bif.phase) != e.phase) begin
          errors++;
          $display("FAIL tick: got cyc=%0d xmit=%0b sample=%0b phase=%0d, expected cyc=%0d xmit=%0b sample=%0b phase=%0d",
                   cyc, bif.xmit_pulse, bif.sample_pulse, bif.phase, e.cyc, e.xmit, e.sample, e.phase);
        end
        if (q.size() == 0) armed = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int a;
    int e2;
    bif.enable = 1'b1;
    bif.load = 1'b0;
    bif.rx_align = 1'b0;
    bif.baud_val = CW'(3);
    bif.baud_frac = FW'(0);
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_baud_clock", int'(bif.baud_clock), 0);
    chk("reset_xmit", int'(bif.xmit_pulse), 0);
    chk("reset_sample", int'(bif.sample_pulse), 0);
    chk("reset_phase", int'(bif.phase), 0);

    // Free run from reset: first tick on the first active edge, then every 4
    reset_n = 1'b1;
    sched(cyc + 1, 3, 0, 32, 0);
    wait_drain("free_run", 400);

    do_load(3, 8, e);
    sched(e + 4, 3, 8, 33, 0);
    wait_drain("frac_half", 400);

    do_load(0, 15, e);
    sched(e + 1, 0, 15, 17, 0);
    wait_drain("frac_15_16", 200);

    do_load(3, 0, e);
    sched(e + 4, 3, 0, 5, 0);
    wait_drain("pre_align", 100);
    step_to(e + 21);
    chk("phase_before_align", int'(bif.phase), 5);
    bif.rx_align = 1'b1;
    a = e + 22;
    step_to(a);
    bif.rx_align = 1'b0;
    chk("align_phase", int'(bif.phase), 0);
    chk("align_no_tick", int'(bif.baud_clock), 0);
    sched(a + 4, 3, 0, 16, 0);
    wait_drain("post_align", 200);

    // Freeze with cnt==2, retarget divisor to 7 while frozen
    do_load(3, 0, e);
    step_to(e + 1);
    bif.enable = 1'b0;
    bif.baud_val = CW'(7);
    sched(e + 14, 7, 0, 4, 0);
    step_to(e + 11);
    bif.enable = 1'b1;
    wait_drain("enable_freeze", 200);

    do_load(3, 0, e);
    sched(e + 4, 3, 0, 8, 0);
    step_to(e + 32);
    chk("pre_reset_baud_clock", int'(bif.baud_clock), 1);
    chk("pre_reset_sample", int'(bif.sample_pulse), 1);
    chk("pre_reset_phase", int'(bif.phase), 8);
    #1 reset_n = 1'b0;
    #1;
    chk("async_reset_baud_clock", int'(bif.baud_clock), 0);
    chk("async_reset_xmit", int'(bif.xmit_pulse), 0);
    chk("async_reset_sample", int'(bif.sample_pulse), 0);
    chk("async_reset_phase", int'(bif.phase), 0);
    #8 reset_n = 1'b1;
    @(negedge clk);
    #1;

    // acc left at 8 after one tick; load+rx_align together must clear it
    do_load(3, 8, e);
    sched(e + 4, 3, 8, 1, 0);
    step_to(e + 5);
    bif.load = 1'b1;
    bif.rx_align = 1'b1;
    e2 = e + 6;
    step_to(e2);
    bif.load = 1'b0;
    bif.rx_align = 1'b0;
    sched(e2 + 4, 3, 8, 3, 0);
    wait_drain("load_and_align", 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
